digit_scanner: RTL and testbench
================================

# digit_scanner

Parametrised multiplexing scanner for common-anode seven-segment displays. It time-slices NUM_DIGITS active-low anode lines, one digit per slot. Between digits it inserts programmable blanking to suppress ghosting, and it skips digits whose mask bit is clear. It sits between the refresh clock domain and the segment decoder; `digit_idx` selects which digit's segment pattern the decoder drives.

## Interface
- NUM_DIGITS, 4: number of anode lines, legal range 2..16.
- TICK_DIV, 100000: clock cycles per digit slot, must be ≥ 2. The slot counter is clog2(TICK_DIV) bits wide.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Legal range 0..TICK_DIV-1; 0 disables blanking.
- IDX_W (localparam), max(1, clog2(NUM_DIGITS)): width of `digit_idx`.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable. When low, the scanner is synchronously cleared and all anodes are off.
- digit_mask  in  NUM_DIGITS  bit k = 1 means digit k takes part in the scan.
- an  out  NUM_DIGITS  anodes, active-low. At most one bit is low at any time; registered.
- digit_idx  out  IDX_W  index of the current slot's digit; registered.
- slot_start  out  1  one-cycle pulse in the first cycle of each new slot; registered.

## Operation
- State: slot counter `cnt` (0..TICK_DIV-1) and current digit `idx`.
- Every clock with enable=1, `cnt` increments.
- At the edge where `cnt` == TICK_DIV-1:
  - `cnt` loads 0 and `slot_start` is set to 1 for that one cycle.
  - `idx` loads the next enabled digit in descending cyclic order: idx-1, idx-2, …, 0, NUM_DIGITS-1, …, using `digit_mask` as sampled at that edge.
  - If the current digit is the only enabled one, `idx` is unchanged.
  - If `digit_mask` is all zero, `idx` holds.
- Scan order for a full mask is NUM_DIGITS-1, NUM_DIGITS-2, …, 0, then wraps.
- `an` is computed at each edge from the `cnt` and `idx` values being loaded at that edge and from `digit_mask` sampled at that edge:
  - all ones if `cnt` < BLANK_CYCLES, or if `digit_mask[idx]` = 0;
  - otherwise `an[idx]` = 0 and all other bits are 1.
- `an`, `digit_idx` and `slot_start` are therefore always mutually consistent in the same cycle.
- Mask changes mid-slot:
  - clearing the current digit's bit turns its anode off at the next edge;
  - `idx` moves only at a slot boundary;
  - setting the current digit's bit mid-slot (outside blanking) turns its anode on at the next edge.
- enable = 0: at each edge `cnt`←0, `idx`←NUM_DIGITS-1, `an`←all ones, `slot_start`←0. On return to enable = 1, the scan restarts exactly as after reset.
- Reset (rst_n = 0, asynchronous, takes effect without a clock edge): `cnt`=0, `idx`=NUM_DIGITS-1, `an`=all ones, `digit_idx`=NUM_DIGITS-1, `slot_start`=0.
- The first slot after reset or enable does not produce a `slot_start` pulse. The first pulse occurs at the first wrap.

## Timing
- Slot length is exactly TICK_DIV cycles.
- Frame length is TICK_DIV × popcount(`digit_mask`) cycles.
- With the defaults at 100 MHz: 1 ms per digit, 4 ms per frame.
- Within each slot, the anode is active for TICK_DIV − BLANK_CYCLES cycles, from cycle BLANK_CYCLES through cycle TICK_DIV-1 of the slot (cnt = 0 is the first cycle).
- A `digit_mask` change affects `an` one cycle later and affects slot selection at the next boundary.
- Deassertion of `enable` blanks `an` one cycle later.
- `rst_n` assertion blanks `an` immediately (asynchronous).

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2 unless noted.

1. Release reset with enable=1, mask=1111 -> `an`=1111 for the first 2 cycles, then 0111 for 6 cycles. At the wrap `slot_start`=1 and `digit_idx`=2, followed by 2 blank cycles and then 1011. `digit_idx` sequence is 3,2,1,0,3,…
2. mask=1010 -> active `an` alternates 0111 / 1101 with `digit_idx` 3,1,3,1. Each slot is 8 cycles and the frame is 16 cycles.
3. mask=0000 -> `an` stays 1111, `digit_idx` holds, and `slot_start` still pulses every 8 cycles. Then set mask=0001 -> at the next wrap `digit_idx`=0, and `an`=1110 after 2 blank cycles.
4. Drop enable mid-slot while `digit_idx`=1 -> next edge gives `an`=1111 and `digit_idx`=3. Raise enable -> 2 blank cycles, then 0111, with no `slot_start` pulse until the first wrap.
5. Assert rst_n=0 while `an`=1101 with clk stopped -> `an`=1111 and `digit_idx`=3 immediately.
6. Build with BLANK_CYCLES=0 and mask=1111 -> exactly one anode is low in every cycle, and each digit switches to the next with no all-ones cycle in between.

Source files
------------

// File: rtl/digit_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// digit_scanner
//
// Multiplexing scanner for common-anode seven-segment displays. Time-slices
// NUM_DIGITS active-low anode lines, one digit per slot of TICK_DIV cycles.
// The first BLANK_CYCLES cycles of each slot keep every anode off so the
// segment decoder can settle without ghosting. Digits whose mask bit is clear
// are skipped. Scan order is descending: NUM_DIGITS-1 down to 0, then wraps.
//
// Ports:
//   clk         in   1           system clock, rising edge
//   rst_n       in   1           asynchronous active-low reset
//   enable      in   1           scan enable; low clears the scanner synchronously
//   digit_mask  in   NUM_DIGITS  bit k = 1 means digit k takes part in the scan
//   an          out  NUM_DIGITS  anodes, active-low, at most one bit low
//   digit_idx   out  IDX_W       digit shown in the current slot
//   slot_start  out  1           one-cycle pulse in the first cycle of a slot
//
// an, digit_idx and slot_start are all registered and are computed from the
// same next-state values, so they always describe the same cycle.
// -----------------------------------------------------------------------------
module digit_scanner #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int TICK_DIV     = 100000,
    parameter  int BLANK_CYCLES = 1000,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  slot_start
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  wrap;
    logic [IDX_W-1:0]      idx_step;
    logic [IDX_W-1:0]      idx_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    int                    cand;

    // NOTE: every signal assigned in this always_comb gets a default before any
    // conditional assignment, otherwise synthesis infers latches.
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        cnt_nxt  = wrap ? '0 : cnt + CNT_W'(1);
        idx_step = digit_idx;
        cand     = 0;

        // Search downward from the farthest candidate to the nearest one, so
        // the closest enabled digit in descending cyclic order wins. If no
        // other digit is enabled, idx_step keeps the current digit.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            cand = int'(digit_idx) - k;
            if (cand < 0) begin
                cand = cand + NUM_DIGITS;
            end
            if (digit_mask[IDX_W'(cand)]) begin
                idx_step = IDX_W'(cand);
            end
        end

        idx_nxt = wrap ? idx_step : digit_idx;

        // Anode follows the values being loaded at this edge, so it lines up
        // with digit_idx and the slot counter in the same cycle.
        an_nxt = '1;
        if ((int'(cnt_nxt) >= BLANK_CYCLES) && digit_mask[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_idx  <= IDX_FIRST;
            an         <= '1;
            slot_start <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            digit_idx  <= IDX_FIRST;
            an         <= '1;
            slot_start <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            an         <= an_nxt;
            slot_start <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
`timescale 1ns/1ps
module tb_digit_scanner;

    localparam int N    = 4;
    localparam int TICK = 8;

    logic         clk;
    logic         clk_run;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] digit_mask;

    logic [N-1:0] an_a, an_b;
    logic [1:0]   idx_a, idx_b;
    logic         ss_a, ss_b;

    int vectors;
    int miscompares;

    // Instance a: blanking of 2 cycles. Instance b: no blanking.
    digit_scanner #(.NUM_DIGITS(N), .TICK_DIV(TICK), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digit_mask(digit_mask),
        .an(an_a), .digit_idx(idx_a), .slot_start(ss_a)
    );

    digit_scanner #(.NUM_DIGITS(N), .TICK_DIV(TICK), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digit_mask(digit_mask),
        .an(an_b), .digit_idx(idx_b), .slot_start(ss_b)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int           pos;    // cycle number within the current slot
        int           digit;  // digit shown in this slot
        logic [N-1:0] an;
        logic         ss;
    } model_t;

    model_t ma, mb;

    function automatic model_t idle_state();
        model_t r;
        r.pos = 0; r.digit = N - 1; r.an = '1; r.ss = 1'b0;
        return r;
    endfunction

    // Nearest enabled digit below d, wrapping; d itself if nothing else is on.
    function automatic int next_digit(int d, logic [N-1:0] mask);
        for (int k = 1; k < N; k++) begin
            int c;
            c = (d + N - k) % N;
            if (mask[c]) return c;
        end
        return d;
    endfunction

    function automatic model_t model_step(model_t s, logic en, logic [N-1:0] mask, int blank);
        model_t r;
        if (!en) return idle_state();
        r = s;
        r.ss = 1'b0;
        if (s.pos == TICK - 1) begin
            r.pos   = 0;
            r.ss    = 1'b1;
            r.digit = next_digit(s.digit, mask);
        end else begin
            r.pos = s.pos + 1;
        end
        r.an = '1;
        if (r.pos >= blank && mask[r.digit]) r.an[r.digit] = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= idle_state();
            mb <= idle_state();
        end else begin
            ma <= model_step(ma, enable, digit_mask, 2);
            mb <= model_step(mb, enable, digit_mask, 0);
        end
    end

    logic [13:0] obs, exp_v;
    assign obs = {an_a, idx_a, ss_a, an_b, idx_b, ss_b};
    always_comb exp_v = {ma.an, 2'(ma.digit), ma.ss, mb.an, 2'(mb.digit), mb.ss};

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; digit_mask = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== {4'hF, 2'd3, 1'b0, 4'hF, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got=%h expected=%h", obs, {4'hF, 2'd3, 1'b0, 4'hF, 2'd3, 1'b0});
        end
    endtask

    task automatic test_full_scan();
        int pulses;
        int exp_seq[4];
        exp_seq = '{2, 1, 0, 3};
        pulses = 0;
        @(negedge clk);
        enable = 1'b1; digit_mask = 4'b1111; rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL full_scan cycle %0d got=%h expected=%h", c, obs, exp_v);
            end
            if (c == 1) begin
                vectors++;
                if (an_a !== 4'b1111) begin
                    miscompares++;
                    $display("FAIL first_blank got=%b expected=1111", an_a);
                end
            end
            if (c == 2) begin
                vectors++;
                if (an_a !== 4'b0111) begin
                    miscompares++;
                    $display("FAIL first_active got=%b expected=0111", an_a);
                end
            end
            if (c == 10) begin
                vectors++;
                if (an_a !== 4'b1011) begin
                    miscompares++;
                    $display("FAIL second_active got=%b expected=1011", an_a);
                end
            end
            if (ss_a === 1'b1) begin
                vectors++;
                if (idx_a !== 2'(exp_seq[pulses % 4]) || (pulses == 0 && c != 8)) begin
                    miscompares++;
                    $display("FAIL scan_order pulse %0d cycle %0d got idx=%0d expected idx=%0d", pulses, c, idx_a, exp_seq[pulses % 4]);
                end
                pulses++;
            end
        end
    endtask

    task automatic test_sparse_mask();
        int guard;
        int prev;
        digit_mask = 4'b1010;
        guard = 0;
        while (ss_a !== 1'b1 && guard < 2 * TICK) begin
            @(negedge clk);
            guard++;
        end
        prev = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sparse_mask cycle %0d got=%h expected=%h", c, obs, exp_v);
            end
            if (ss_a === 1'b1) begin
                vectors++;
                if (!(idx_a === 2'd1 || idx_a === 2'd3) || int'(idx_a) == prev) begin
                    miscompares++;
                    $display("FAIL sparse_order got idx=%0d expected alternate of %0d among 1/3", idx_a, prev);
                end
                prev = int'(idx_a);
            end
        end
    endtask

    task automatic test_zero_mask();
        int pulses;
        int guard;
        digit_mask = 4'b0000;
        @(negedge clk);
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v || an_a !== 4'b1111) begin
                miscompares++;
                $display("FAIL zero_mask cycle %0d got=%h expected=%h", c, obs, exp_v);
            end
            if (ss_a === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL zero_mask_pulses got=%0d expected=3", pulses);
        end
        digit_mask = 4'b0001;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ss_a !== 1'b1 && guard < TICK + 1);
        vectors++;
        if (ss_a !== 1'b1 || idx_a !== 2'd0) begin
            miscompares++;
            $display("FAIL single_digit_wrap got ss=%b idx=%0d expected ss=1 idx=0", ss_a, idx_a);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (an_a !== 4'b1110 || obs !== exp_v) begin
            miscompares++;
            $display("FAIL single_digit_on got=%b expected=1110", an_a);
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        digit_mask = 4'b1111;
        guard = 0;
        while (!(idx_a === 2'd1 && ss_a === 1'b0) && guard < 5 * TICK) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (idx_a !== 2'd1) begin
            miscompares++;
            $display("FAIL enable_drop_wait got idx=%0d expected 1 before timeout", idx_a);
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (an_a !== 4'b1111 || idx_a !== 2'd3 || ss_a !== 1'b0 || obs !== exp_v) begin
            miscompares++;
            $display("FAIL enable_drop got an=%b idx=%0d ss=%b expected an=1111 idx=3 ss=0", an_a, idx_a, ss_a);
        end
        enable = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v ||
                (c == 1 && an_a !== 4'b1111) ||
                (c == 2 && an_a !== 4'b0111) ||
                (c < 8 && ss_a !== 1'b0) ||
                (c == 8 && (ss_a !== 1'b1 || idx_a !== 2'd2))) begin
                miscompares++;
                $display("FAIL enable_restart cycle %0d got=%h expected=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_no_blank();
        digit_mask = 4'b1111;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            vectors++;
            if ($countones(~an_b) != 1 || obs !== exp_v) begin
                miscompares++;
                $display("FAIL no_blank cycle %0d got an=%b idx=%0d expected one-hot low (model %h)", c, an_b, idx_b, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random cycle %0d mask=%b en=%b got=%h expected=%h", c, digit_mask, enable, obs, exp_v);
            end
            if ($urandom_range(7, 0) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(39, 0) == 0) enable = ~enable;
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int guard;
        digit_mask = 4'b1111;
        guard = 0;
        while (an_a !== 4'b1101 && guard < 6 * TICK) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (an_a !== 4'b1101) begin
            miscompares++;
            $display("FAIL async_reset_wait got an=%b expected 1101 before timeout", an_a);
        end
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (an_a !== 4'b1111 || idx_a !== 2'd3 || ss_a !== 1'b0 || obs !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset got an=%b idx=%0d ss=%b expected an=1111 idx=3 ss=0", an_a, idx_a, ss_a);
        end
        #10;
        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL after_reset cycle %0d got=%h expected=%h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_run     = 1'b1;
        rst_n       = 1'b0;
        enable      = 1'b0;
        digit_mask  = '0;
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_zero_mask();
        test_enable_drop();
        test_no_blank();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
